// File: rtl/dwt_pair_packer.sv
// dwt_pair_packer
// Front-end of the 1D DWT 9/7 lifting datapath. Packs a serial sample stream
// into {odd, even} pairs and carries sof/eol along with each pair. An
// odd-length line is closed with a whole-sample symmetric extension, so the
// lifting unit downstream always receives complete pairs.
//
// Ports:
//   clk_i, rst_i          clock and synchronous active-high reset
//   s_valid_i/s_ready_o   input handshake; s_ready_o = !m_valid_o | m_ready_i
//   s_sof_i, s_eol_i      first sample of the frame / last sample of the line
//   s_data_i              sample x[n]
//   m_valid_o/m_ready_i   output handshake
//   m_sof_o, m_eol_o      pair holds the frame's first sample / last pair of the line
//   m_data_o              {x[2k+1], x[2k]}
//   err_o                 only when DWT_PAIR_PACKER_LEN_CHECK_EN is defined:
//                         sticky flag for an over-long line or a sof arriving
//                         while an even sample is held
module dwt_pair_packer #(
  parameter int DataWidth       = 16,
  parameter int MaximumSideSize = 512
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  output logic                   s_ready_o,
  input  logic                   s_valid_i,
  input  logic                   s_sof_i,
  input  logic                   s_eol_i,
  input  logic [DataWidth-1:0]   s_data_i,
  input  logic                   m_ready_i,
  output logic                   m_valid_o,
  output logic                   m_sof_o,
  output logic                   m_eol_o,
`ifdef DWT_PAIR_PACKER_LEN_CHECK_EN
  output logic [2*DataWidth-1:0] m_data_o,
  output logic                   err_o
`else
  output logic [2*DataWidth-1:0] m_data_o
`endif
);

  typedef enum logic {ST_EVEN, ST_ODD} state_t;

  state_t                 r_state, w_state_n;
  logic [DataWidth-1:0]   r_even, r_last_odd;
  logic                   r_sof, r_has_odd;
  logic                   r_m_valid, r_m_sof, r_m_eol;
  logic [2*DataWidth-1:0] r_m_data;

  logic                   w_beat, w_as_even, w_line_has_odd, w_load;
  logic                   w_ld_sof, w_ld_eol;
  logic [2*DataWidth-1:0] w_ld_data;

  assign s_ready_o = !r_m_valid | m_ready_i;
  assign m_valid_o = r_m_valid;
  assign m_sof_o   = r_m_sof;
  assign m_eol_o   = r_m_eol;
  assign m_data_o  = r_m_data;

  assign w_beat = s_valid_i & s_ready_o;
  // A sof beat while an even sample is held drops that sample: the beat is
  // handled exactly as if the FSM were waiting for an even sample, and it
  // starts a fresh line, so no earlier odd sample may be used for extension.
  assign w_as_even      = (r_state == ST_EVEN) | s_sof_i;
  assign w_line_has_odd = r_has_odd & ~s_sof_i;

  always_comb begin
    w_state_n = r_state;
    w_load    = 1'b0;
    w_ld_sof  = 1'b0;
    w_ld_eol  = 1'b0;
    w_ld_data = '0;
    if (w_beat) begin
      if (w_as_even) begin
        if (s_eol_i) begin
          w_load    = 1'b1;
          w_ld_sof  = s_sof_i;
          w_ld_eol  = 1'b1;
          w_ld_data = {(w_line_has_odd ? r_last_odd : s_data_i), s_data_i};
          w_state_n = ST_EVEN;
        end else begin
          w_state_n = ST_ODD;
        end
      end else begin
        w_load    = 1'b1;
        w_ld_sof  = r_sof;
        w_ld_eol  = s_eol_i;
        w_ld_data = {s_data_i, r_even};
        w_state_n = ST_EVEN;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state    <= ST_EVEN;
      r_even     <= '0;
      r_last_odd <= '0;
      r_sof      <= 1'b0;
      r_has_odd  <= 1'b0;
      r_m_valid  <= 1'b0;
      r_m_sof    <= 1'b0;
      r_m_eol    <= 1'b0;
      r_m_data   <= '0;
    end else begin
      r_state <= w_state_n;
      if (w_beat) begin
        if (w_as_even) begin
          if (s_eol_i) begin
            r_has_odd <= 1'b0;
          end else begin
            r_even    <= s_data_i;
            r_sof     <= s_sof_i;
            r_has_odd <= w_line_has_odd;
          end
        end else begin
          r_last_odd <= s_data_i;
          r_has_odd  <= ~s_eol_i;
        end
      end
      if (w_load) begin
        r_m_valid <= 1'b1;
        r_m_sof   <= w_ld_sof;
        r_m_eol   <= w_ld_eol;
        r_m_data  <= w_ld_data;
      end else if (m_ready_i) begin
        r_m_valid <= 1'b0;
      end
    end
  end

`ifdef DWT_PAIR_PACKER_LEN_CHECK_EN
  localparam int CntW = $clog2(MaximumSideSize) + 1;
  localparam logic [CntW-1:0] CntMax = CntW'(MaximumSideSize);

  logic [CntW-1:0] r_cnt;
  logic            r_err;

  assign err_o = r_err;

  // r_cnt is the number of samples already seen on the current line; a beat
  // arriving with r_cnt at the maximum is sample MaximumSideSize+1.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_cnt <= '0;
      r_err <= 1'b0;
    end else if (w_beat) begin
      if (r_cnt == CntMax) r_err <= 1'b1;
      if ((r_state == ST_ODD) && s_sof_i) r_err <= 1'b1;
      if (s_eol_i) begin
        r_cnt <= '0;
      end else if (r_cnt != CntMax) begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_dwt_pair_packer.sv
module tb_dwt_pair_packer;
  localparam int W = 16;

  logic           clk = 1'b0;
  logic           rst;
  logic           s_ready, s_valid, s_sof, s_eol;
  logic [W-1:0]   s_data;
  logic           m_ready, m_valid, m_sof, m_eol;
  logic [2*W-1:0] m_data;
`ifdef DWT_PAIR_PACKER_LEN_CHECK_EN
  logic           err;
`endif

  always #5 clk = ~clk;

  dwt_pair_packer #(.DataWidth(W), .MaximumSideSize(512)) dut (
    .clk_i     (clk),
    .rst_i     (rst),
    .s_ready_o (s_ready),
    .s_valid_i (s_valid),
    .s_sof_i   (s_sof),
    .s_eol_i   (s_eol),
    .s_data_i  (s_data),
    .m_ready_i (m_ready),
    .m_valid_o (m_valid),
    .m_sof_o   (m_sof),
    .m_eol_o   (m_eol),
`ifdef DWT_PAIR_PACKER_LEN_CHECK_EN
    .m_data_o  (m_data),
    .err_o     (err)
`else
    .m_data_o  (m_data)
`endif
  );

  // expected entry: {odd, even, sof, eol}
  logic [2*W+1:0] q[$];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic expect_pair(input logic [W-1:0] odd, input logic [W-1:0] even,
                             input logic sof, input logic eol);
    q.push_back({odd, even, sof, eol});
  endtask

  // Monitor: every output transfer pops one expected pair.
  always @(negedge clk) begin
    if (!rst && m_valid && m_ready) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_pair: got %0h expected none", {m_data, m_sof, m_eol});
      end else begin
        chk("pair", {m_data, m_sof, m_eol}, q.pop_front());
      end
    end
  end

  task automatic send(input logic [W-1:0] d, input logic sof, input logic eol);
    int n = 0;
    s_valid = 1'b1;
    s_data  = d;
    s_sof   = sof;
    s_eol   = eol;
    @(negedge clk);
    while (!s_ready && n < 50) begin
      n++;
      @(negedge clk);
    end
    if (!s_ready) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: got ready=0 expected ready=1");
    end
    @(posedge clk);
    #1;
    s_valid = 1'b0;
    s_sof   = 1'b0;
    s_eol   = 1'b0;
  endtask

  initial begin
    logic [2*W-1:0] held;
    int n;
    rst = 1'b1; s_valid = 1'b0; s_sof = 1'b0; s_eol = 1'b0; s_data = '0; m_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    chk("rst_valid", m_valid, 0);
    chk("rst_sof",   m_sof,   0);
    chk("rst_eol",   m_eol,   0);
    chk("rst_data",  m_data,  0);
    chk("rst_ready", s_ready, 1);
`ifdef DWT_PAIR_PACKER_LEN_CHECK_EN
    chk("rst_err", err, 0);
`endif

    // even-length line
    expect_pair(20, 10, 1, 0);
    expect_pair(40, 30, 0, 1);
    send(10, 1, 0);
    chk("no_early_valid", m_valid, 0);
    send(20, 0, 0);
    chk("latency_valid", m_valid, 1);
    send(30, 0, 0);
    send(40, 0, 1);

    // odd-length line: last pair extended with x[3]
    expect_pair(2, 1, 1, 0);
    expect_pair(4, 3, 0, 0);
    expect_pair(4, 5, 0, 1);
    send(1, 1, 0); send(2, 0, 0); send(3, 0, 0); send(4, 0, 0); send(5, 0, 1);

    // single-sample line
    expect_pair(7, 7, 1, 1);
    send(7, 1, 1);
    @(posedge clk); #1;

    // backpressure
    expect_pair(101, 100, 1, 0);
    expect_pair(103, 102, 0, 1);
    m_ready = 1'b0;
    fork
      begin
        send(100, 1, 0); send(101, 0, 0); send(102, 0, 0); send(103, 0, 1);
      end
      begin
        n = 0;
        @(negedge clk);
        while (!m_valid && n < 50) begin n++; @(negedge clk); end
        chk("bp_valid", m_valid, 1);
        held = m_data;
        repeat (3) begin
          @(negedge clk);
          chk("bp_ready", s_ready, 0);
          chk("bp_stable", m_data, held);
        end
        @(posedge clk); #1;
        m_ready = 1'b1;
      end
    join

    // resynchronisation: sof while an even sample is held
    expect_pair(8, 9, 1, 1);
    send(1, 1, 0); send(9, 1, 0); send(8, 0, 1);
`ifdef DWT_PAIR_PACKER_LEN_CHECK_EN
    chk("resync_err", err, 1);
`endif
    repeat (2) @(posedge clk); #1;

    // reset between the even and odd sample
    send(5, 1, 0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("midrst_valid", m_valid, 0);
    expect_pair(7, 6, 0, 1);
    send(6, 0, 0);
    send(7, 0, 1);

    n = 0;
    while (q.size() != 0 && n < 100) begin n++; @(posedge clk); end
    repeat (3) @(posedge clk);
    chk("queue_drained", q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
